// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: latches one instruction per start handshake and steps
// through T0..T3 driving register-file, ALU, immediate and display strobes.
package ctrl_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3
  } state_t;

  typedef enum logic [3:0] {
    OP_DISP = 4'd0,
    OP_LOAD = 4'd1,
    OP_MOVE = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_ADDI = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8
  } opcode_t;

endpackage

module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int FCN_W      = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [4+3*REG_ADDR_W-1:0] instr,
  output logic                    busy,
  output logic                    done,
  output logic                    illegal,
  output logic                    data_enable,
  output logic                    reg_in_en,
  output logic [REG_ADDR_W-1:0]   reg_in_addr,
  output logic                    reg_out_en,
  output logic [REG_ADDR_W-1:0]   reg_out_addr,
  output logic                    alu_load_a,
  output logic                    alu_load_b,
  output logic                    alu_store,
  output logic [FCN_W-1:0]        fcn,
  output logic                    imm_enable,
  output logic [REG_ADDR_W-1:0]   imm_value,
  output logic                    display_enable,
  output logic [REG_ADDR_W-1:0]   display_value,
  output logic [3:0]              step
);

  localparam int IW = 4 + 3*REG_ADDR_W;
  localparam int R  = REG_ADDR_W;

  localparam logic [FCN_W-1:0] FCN_ADD = FCN_W'(1);
  localparam logic [FCN_W-1:0] FCN_SUB = FCN_W'(2);
  localparam logic [FCN_W-1:0] FCN_AND = FCN_W'(3);
  localparam logic [FCN_W-1:0] FCN_OR  = FCN_W'(4);
  localparam logic [FCN_W-1:0] FCN_XOR = FCN_W'(5);

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   instr_q;
  logic            accept;
  logic            last;

  logic [3:0]      opcode;
  logic [R-1:0]    p1;
  logic [R-1:0]    p2;
  logic [R-1:0]    p3;

  logic            is_disp;
  logic            is_load;
  logic            is_move;
  logic            is_addi;
  logic            is_alu;
  logic            is_illegal;
  logic [FCN_W-1:0] alu_fcn;

  assign opcode = instr_q[IW-1 -: 4];
  assign p1     = instr_q[3*R-1 -: R];
  assign p2     = instr_q[2*R-1 -: R];
  assign p3     = instr_q[R-1:0];

  assign is_disp    = (opcode == OP_DISP);
  assign is_load    = (opcode == OP_LOAD);
  assign is_move    = (opcode == OP_MOVE);
  assign is_addi    = (opcode == OP_ADDI);
  assign is_alu     = (opcode >= OP_ADD) && (opcode <= OP_XOR);
  assign is_illegal = (opcode > OP_XOR);

  always_comb begin
    alu_fcn = '0;
    unique case (1'b1)
      opcode == OP_ADD:  alu_fcn = FCN_ADD;
      opcode == OP_SUB:  alu_fcn = FCN_SUB;
      opcode == OP_ADDI: alu_fcn = FCN_ADD;
      opcode == OP_AND:  alu_fcn = FCN_AND;
      opcode == OP_OR:   alu_fcn = FCN_OR;
      opcode == OP_XOR:  alu_fcn = FCN_XOR;
      default:           alu_fcn = '0;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_comb begin
    step = 4'b0000;
    unique case (state_q)
      S_T0:    step = 4'b0001;
      S_T1:    step = 4'b0010;
      S_T2:    step = 4'b0100;
      S_T3:    step = 4'b1000;
      default: step = 4'b0000;
    endcase
  end

  always_comb begin
    data_enable    = 1'b0;
    reg_in_en      = 1'b0;
    reg_in_addr    = '0;
    reg_out_en     = 1'b0;
    reg_out_addr   = '0;
    alu_load_a     = 1'b0;
    alu_load_b     = 1'b0;
    alu_store      = 1'b0;
    fcn            = '0;
    imm_enable     = 1'b0;
    imm_value      = '0;
    display_enable = 1'b0;
    display_value  = '0;
    last           = 1'b0;
    if (state_q != S_IDLE) begin
      unique case (1'b1)
        is_disp: begin
          if (state_q == S_T0) begin
            reg_out_en     = 1'b1;
            reg_out_addr   = p1;
            display_enable = 1'b1;
            display_value  = p2;
          end
          last = (state_q == S_T1);
        end
        is_load: begin
          if (state_q == S_T0) begin
            reg_in_en   = 1'b1;
            reg_in_addr = p1;
            data_enable = 1'b1;
          end
          last = (state_q == S_T1);
        end
        is_move: begin
          if (state_q == S_T0) begin
            reg_out_en   = 1'b1;
            reg_out_addr = p1;
            reg_in_en    = 1'b1;
            reg_in_addr  = p2;
          end
          last = (state_q == S_T1);
        end
        is_alu: begin
          fcn = alu_fcn;
          unique case (state_q)
            S_T0: begin
              reg_out_en   = 1'b1;
              reg_out_addr = p2;
              alu_load_a   = 1'b1;
            end
            S_T1: begin
              alu_load_b = 1'b1;
              if (is_addi) begin
                imm_enable = 1'b1;
                imm_value  = p3;
              end else begin
                reg_out_en   = 1'b1;
                reg_out_addr = p3;
              end
            end
            S_T2: alu_store = 1'b1;
            S_T3: begin
              reg_in_en   = 1'b1;
              reg_in_addr = p1;
              last        = 1'b1;
            end
            default: ;
          endcase
        end
        default: last = 1'b1;
      endcase
    end
  end

  // an aborted final step must not look like a completion
  assign done    = last & ~abort;
  assign illegal = done & is_illegal;
  assign accept  = start & ((state_q == S_IDLE) | done);

  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (start) state_d = S_T0;
    end else if (abort) begin
      state_d = S_IDLE;
    end else if (accept) begin
      state_d = S_T0;
    end else if (last) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_T0:    state_d = S_T1;
        S_T1:    state_d = S_T2;
        S_T2:    state_d = S_T3;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) instr_q <= instr;
    end
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised instruction sequencer for the SimpleProcessor datapath. It accepts one instruction per `start` handshake and latches it. It then steps through the instruction with its own internal step counter, driving register-file, ALU, immediate and display control strobes, and pulses `done` on the final step. It replaces an externally supplied step vector and adds register-address width scaling, logic ops, real immediates, illegal-opcode detection, abort and back-to-back issue.

## Interface
Parameters:
- `REG_ADDR_W`, default 3: width of each register-address field (p1, p2, p3) and of `imm_value`/`display_value`.
- `FCN_W`, default 4: width of the ALU function code `fcn`.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears all state.
- `start`  in  1  issue request; sampled only when the block can accept.
- `abort`  in  1  synchronous cancel of the current instruction.
- `instr`  in  4+3*REG_ADDR_W  {opcode[3:0], p1, p2, p3}; p3 is the LSBs.
- `busy`  out  1  high in any non-IDLE state.
- `done`  out  1  one-cycle pulse on the final step.
- `illegal`  out  1  high with `done` when the opcode is undefined.
- `data_enable`  out  1  external data bus drives the register write.
- `reg_in_en`  out  1  register write enable.
- `reg_in_addr`  out  REG_ADDR_W  register write address.
- `reg_out_en`  out  1  register read enable.
- `reg_out_addr`  out  REG_ADDR_W  register read address.
- `alu_load_a`  out  1  ALU operand A capture.
- `alu_load_b`  out  1  ALU operand B capture.
- `alu_store`  out  1  ALU result register capture.
- `fcn`  out  FCN_W  ALU function code.
- `imm_enable`  out  1  immediate drives the operand bus instead of the register file.
- `imm_value`  out  REG_ADDR_W  immediate value (p3).
- `display_enable`  out  1  display latch enable.
- `display_value`  out  REG_ADDR_W  display selector (p2).
- `step`  out  4  one-hot current step (T0..T3); 0 in IDLE.

## Operation
- Opcodes: 0 DISP, 1 LOAD, 2 MOVE, 3 ADD, 4 SUB, 5 ADDI, 6 AND, 7 OR, 8 XOR. Opcodes 9–15 are illegal.
- States: IDLE, T0, T1, T2, T3.
- Accepting an instruction: `start` is accepted in IDLE, or in the final step while `done`=1. On acceptance `instr` is latched and the next state is T0. `start` in any other state is ignored.
- All outputs decode combinationally from the state and the latched instruction. Every output is 0 in IDLE and during reset.
- DISP:
  - T0: `reg_out_en`, `reg_out_addr`=p1, `display_enable`, `display_value`=p2.
  - T1: `done`.
- LOAD:
  - T0: `reg_in_en`, `reg_in_addr`=p1, `data_enable`.
  - T1: `done`.
- MOVE:
  - T0: `reg_out_en`, `reg_out_addr`=p1, `reg_in_en`, `reg_in_addr`=p2.
  - T1: `done`.
- ALU ops (ADD, SUB, AND, OR, XOR, ADDI):
  - `fcn` is held for T0..T3: ADD=1, SUB=2, AND=3, OR=4, XOR=5, ADDI=1.
  - T0: `reg_out_en`, `reg_out_addr`=p2, `alu_load_a`.
  - T1: `reg_out_en`, `reg_out_addr`=p3, `alu_load_b`. For ADDI, `reg_out_en`=0 and `imm_enable`=1 instead.
  - T2: `alu_store`.
  - T3: `reg_in_en`, `reg_in_addr`=p1, `done`.
- `imm_value` equals p3 only while `imm_enable`=1, else 0. Zero-extension is done downstream.
- Illegal opcode: T0 only, with `done`=1 and `illegal`=1 and no other strobes.
- Address fields are passed through unmodified; no arithmetic is performed in this block.

## Timing
- Latency from `start` accepted in IDLE to `done`:
  - 2 cycles for DISP, LOAD, MOVE.
  - 4 cycles for ALU ops.
  - 1 cycle for illegal opcodes.
- Back-to-back issue: `start` with `done`=1 moves directly to T0 of the new instruction, with no IDLE bubble.
- `abort`=1 in any non-IDLE state goes to IDLE at the next edge. No `done` is produced; the current step's strobes still assert in that cycle.
- `abort` has priority over `start`. `abort` in IDLE has no effect.
- Reset asserted mid-instruction: outputs drop to 0 immediately (asynchronously), the state is IDLE, and the latched instruction is cleared to 0.
- `busy` falls in the cycle after `done` unless a new instruction was chained.

## Test plan
- Reset, then ADD p1=5, p2=1, p3=2:
  - Step sequence T0..T3.
  - Read address 1 then 2; `fcn`=1 for four cycles.
  - `alu_store` in T2; write to address 5 in T3 with `done`=1.
  - `busy` low the next cycle.
- ADDI p1=3, p2=4, p3=6:
  - T1 has `imm_enable`=1, `imm_value`=6, `reg_out_en`=0.
  - Write to address 3 in T3.
- LOAD p1=7, then MOVE p1=7, p2=2 issued with `start` during LOAD's T1:
  - MOVE's T0 follows LOAD's T1 directly.
  - MOVE's T0 has read address 7 and write address 2.
- Opcode 12:
  - One cycle with `done`=1 and `illegal`=1, no strobes, then IDLE.
- Abort and reset mid-instruction:
  - SUB aborted in T1: T2 is never entered, no `done`, IDLE next cycle; a `start` held high in the same cycle is ignored.
  - Separately, async `reset` asserted in T2 of XOR: all outputs 0 immediately, `step`=0.
- REG_ADDR_W=4, DISP p1=15, p2=9:
  - `reg_out_addr`=15 and `display_value`=9 in T0.
  - `done` in T1.
